// File: rtl/dpll_pkg.sv
// Shared DPLL loop-filter defaults and helpers.
package dpll_pkg;

  localparam int DPLL_CNT_W    = 10;
  localparam int DPLL_KEXP_OFS = 3;
  localparam int DPLL_LOCK_W   = 12;
  localparam int DPLL_LOCK_LEN = 2000;

  // Effective exponent, clamped to the counter width.
  function automatic int kc_of(
    input int kexp,
    input int ofs,
    input int cnt_w
  );
    int s;
    s = kexp + ofs;
    if (s > cnt_w) s = cnt_w;
    return s;
  endfunction

  // Terminal count 2^kc - 1.
  function automatic logic [31:0] term_val(input int kc);
    return (32'd1 << kc) - 32'd1;
  endfunction

endpackage

// File: rtl/mod_k_counter.sv
// Modulo-2^kc counter with a registered wrap pulse.
import dpll_pkg::*;

module mod_k_counter #(
  parameter int CNT_W = DPLL_CNT_W,
  parameter int KC_W  = $clog2(CNT_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  input  logic [KC_W-1:0]  kc,
  output logic             wrap,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic [CNT_W-1:0] term;

  assign term = CNT_W'(term_val(int'(kc)));

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      if (cnt_q == term) begin
        cnt_d  = '0;
        wrap_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign cnt  = cnt_q;
  assign wrap = wrap_q;

endmodule

// File: rtl/kcounter_loop_filter.sv
// K-counter DPLL loop filter: up/down modulo-K
// integrators, carry/borrow pulses and lock timer.
import dpll_pkg::*;

module kcounter_loop_filter #(
  parameter int CNT_W    = DPLL_CNT_W,
  parameter int KEXP_OFS = DPLL_KEXP_OFS,
  parameter int LOCK_W   = DPLL_LOCK_W,
  parameter int LOCK_LEN = DPLL_LOCK_LEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             dnUp,
  input  logic [2:0]       kExp,
  output logic             carry,
  output logic             borrow,
  output logic             lock,
  output logic [CNT_W-1:0] upCnt,
  output logic [CNT_W-1:0] dnCnt
);

  localparam int KC_W = $clog2(CNT_W + 1);
  localparam logic [LOCK_W-1:0] LOCK_MAX =
    LOCK_W'(LOCK_LEN);

  logic [2:0]        kreg_q, kreg_d;
  logic [LOCK_W-1:0] tmr_q, tmr_d;
  logic              lock_q, lock_d;

  logic [KC_W-1:0]   kc;
  logic [CNT_W-1:0]  term;
  logic              kchg;
  logic              inc_up, inc_dn;
  logic              wrap_now;

  assign kc   = KC_W'(kc_of(int'(kreg_q), KEXP_OFS, CNT_W));
  assign term = CNT_W'(term_val(int'(kc)));
  assign kchg = (kExp != kreg_q);

  assign inc_up = enable & ~dnUp & ~kchg;
  assign inc_dn = enable &  dnUp & ~kchg;

  // Pulse about to be registered on this edge.
  assign wrap_now = (inc_up && upCnt == term)
                 || (inc_dn && dnCnt == term);

  mod_k_counter #(.CNT_W(CNT_W), .KC_W(KC_W)) u_up (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_up),
    .clr   (kchg),
    .kc    (kc),
    .wrap  (carry),
    .cnt   (upCnt)
  );

  mod_k_counter #(.CNT_W(CNT_W), .KC_W(KC_W)) u_dn (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_dn),
    .clr   (kchg),
    .kc    (kc),
    .wrap  (borrow),
    .cnt   (dnCnt)
  );

  always_comb begin
    kreg_d = kExp;
    tmr_d  = tmr_q;
    lock_d = lock_q;
    if (kchg || wrap_now) begin
      tmr_d  = '0;
      lock_d = 1'b0;
    end else if (enable) begin
      if (tmr_q != LOCK_MAX) tmr_d = tmr_q + 1'b1;
      lock_d = lock_q | (tmr_d == LOCK_MAX);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kreg_q <= '0;
      tmr_q  <= '0;
      lock_q <= 1'b0;
    end else begin
      kreg_q <= kreg_d;
      tmr_q  <= tmr_d;
      lock_q <= lock_d;
    end
  end

  assign lock = lock_q;

endmodule

// File: tb/tb_kcounter_loop_filter.sv
// Directed bench for kcounter_loop_filter.
// Expected values are hand-derived per scenario.
module tb_kcounter_loop_filter;

  localparam int CNT_W = 10;

  logic             clk;
  logic             reset;
  logic             enable;
  logic             dnUp;
  logic [2:0]       kExp;
  logic             carry;
  logic             borrow;
  logic             lock;
  logic [CNT_W-1:0] upCnt;
  logic [CNT_W-1:0] dnCnt;

  int n_chk;
  int n_bad;
  int npulse;

  kcounter_loop_filter dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .dnUp   (dnUp),
    .kExp   (kExp),
    .carry  (carry),
    .borrow (borrow),
    .lock   (lock),
    .upCnt  (upCnt),
    .dnCnt  (dnCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_carry"},  32'(carry),  0);
    check({tag, "_borrow"}, 32'(borrow), 0);
    check({tag, "_lock"},   32'(lock),   0);
    check({tag, "_up"},     32'(upCnt),  0);
    check({tag, "_dn"},     32'(dnCnt),  0);
  endtask

  initial begin
    n_chk  = 0;
    n_bad  = 0;
    reset  = 1'b0;
    enable = 1'b0;
    dnUp   = 1'b0;
    kExp   = 3'd0;
    #12;
    check_all_zero("rst");
    #1 reset = 1'b1;

    // Wrap up, K=8.
    enable = 1'b1;
    dnUp   = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      check("t1_carry", 32'(carry),
            32'(i == 8 || i == 16));
      check("t1_borrow", 32'(borrow), 0);
    end
    check("t1_up", 32'(upCnt), 4);
    check("t1_dn", 32'(dnCnt), 0);

    // kExp 0->1 clears, then wrap down, K=16.
    kExp = 3'd1;
    step();
    check("t2_chg_up", 32'(upCnt), 0);
    check("t2_chg_carry", 32'(carry), 0);
    dnUp = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      check("t2_borrow", 32'(borrow), 32'(i == 16));
      check("t2_carry", 32'(carry), 0);
    end
    check("t2_dn", 32'(dnCnt), 0);
    check("t2_up", 32'(upCnt), 0);

    // Back to K=8, alternate directions.
    kExp = 3'd0;
    step();
    check("t3_chg_dn", 32'(dnCnt), 0);
    npulse = 0;
    for (int i = 0; i < 14; i++) begin
      dnUp = i[0];
      step();
      npulse += int'(carry) + int'(borrow);
    end
    check("t3_up", 32'(upCnt), 7);
    check("t3_dn", 32'(dnCnt), 7);
    check("t3_pulses", 32'(npulse), 0);
    enable = 1'b0;
    dnUp   = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("t3_hold_up", 32'(upCnt), 7);
    check("t3_hold_dn", 32'(dnCnt), 7);
    check("t3_hold_carry", 32'(carry), 0);
    enable = 1'b1;
    step();
    check("t3_carry", 32'(carry), 1);
    check("t3_up_wrap", 32'(upCnt), 0);
    check("t3_dn_kept", 32'(dnCnt), 7);
    enable = 1'b0;
    step();
    check("t3_carry_1cyc", 32'(carry), 0);

    // Mid-count kExp change to 2 (K=32).
    enable = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("t4_up5", 32'(upCnt), 5);
    kExp = 3'd2;
    step();
    check("t4_chg_up", 32'(upCnt), 0);
    check("t4_chg_lock", 32'(lock), 0);
    check("t4_chg_carry", 32'(carry), 0);
    npulse = 0;
    for (int i = 1; i <= 31; i++) begin
      step();
      npulse += int'(carry);
    end
    check("t4_no_early", 32'(npulse), 0);
    check("t4_up31", 32'(upCnt), 31);
    step();
    check("t4_carry32", 32'(carry), 1);

    // Lock with K=1024, alternating: 1000 per side.
    kExp = 3'd7;
    step();
    check("t5_chg_lock", 32'(lock), 0);
    npulse = 0;
    for (int i = 1; i <= 2000; i++) begin
      dnUp = ~i[0];
      step();
      npulse += int'(carry) + int'(borrow);
      if (i == 1999) check("t5_lock1999", 32'(lock), 0);
      if (i == 2000) check("t5_lock2000", 32'(lock), 1);
    end
    check("t5_pulses", 32'(npulse), 0);
    check("t5_up", 32'(upCnt), 1000);
    check("t5_dn", 32'(dnCnt), 1000);
    dnUp = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      step();
      if (i == 23) begin
        check("t5_lock_held", 32'(lock), 1);
        check("t5_up1023", 32'(upCnt), 1023);
      end
    end
    check("t5_carry", 32'(carry), 1);
    check("t5_lock_drop", 32'(lock), 0);

    // Async reset truncating a live carry pulse.
    kExp = 3'd0;
    step();
    for (int i = 0; i < 8; i++) step();
    check("t6_carry_pre", 32'(carry), 1);
    #2 reset = 1'b0;
    #1;
    check_all_zero("t6_async");
    #2 reset = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check("t6_carry", 32'(carry), 32'(i == 8));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/kcounter_loop_filter.md
Name: kcounter_loop_filter

Overview:
- K-counter loop filter for the DPLL: sits directly downstream of the sampling flip-flop phase detector and consumes its registered lead/lag bit (dnUp).
- Integrates that bit with two modulo-K counters and emits one-cycle carry/borrow pulses to the increment/decrement (DCO) stage.
- Also provides a lock indicator and a debug view of the counters.
- K is programmable at run time in powers of two.

Parameters:
- CNT_W, 10, counter width; maximum modulus is 2^CNT_W.
- KEXP_OFS, 3, exponent offset; K = 2^(kExp+KEXP_OFS), clamped to 2^CNT_W.
- LOCK_W, 12, lock-timer width.
- LOCK_LEN, 2000, number of pulse-free enabled cycles required to declare lock; must be < 2^LOCK_W.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  count qualifier (phase-detector sample strobe).
- dnUp  input  1  phase-detector output; 1 = count down, 0 = count up.
- kExp  input  3  modulus exponent.
- carry  output  1  one-cycle pulse on up-counter wrap.
- borrow  output  1  one-cycle pulse on down-counter wrap.
- lock  output  1  loop locked.
- upCnt  output  CNT_W  up-counter value (debug).
- dnCnt  output  CNT_W  down-counter value (debug).

Behaviour:
- Reset (reset=0, asynchronous, active-low; clock clk): upCnt=0, dnCnt=0, carry=0, borrow=0, lock=0, lockTmr=0, kReg=kExp value 0.
- Modulus:
  - Kc = min(kReg+KEXP_OFS, CNT_W).
  - Terminal value T = 2^Kc - 1.
  - Compare on the low Kc bits only; the upper counter bits stay 0.
- kExp change: kExp is registered into kReg every cycle. When kExp != kReg:
  - upCnt, dnCnt and lockTmr clear to 0 and lock drops to 0.
  - carry/borrow stay 0 and no counting happens that cycle.
  - The new K takes effect from the following cycle.
- Counting, per rising edge, with enable=1 and no kExp change:
  - dnUp=0: if upCnt==T, then upCnt<=0 and carry<=1; otherwise upCnt<=upCnt+1 and carry<=0. dnCnt holds; borrow<=0.
  - dnUp=1: the mirror case on dnCnt/borrow; upCnt holds; carry<=0.
- enable=0: counters hold; carry=borrow=0.
- Latency: carry/borrow are registered and assert in the cycle right after the edge that sampled the K-th qualifying count.
  - For K=8 from reset: carry is high after the 8th enabled dnUp=0 edge, for exactly one cycle.
- Pulse exclusivity: carry and borrow are never high together. Both are cleared unless their own wrap occurs.
- The two counters are independent: counting in one direction never clears the other.
- Lock timer:
  - Any edge that sets carry or borrow clears lockTmr to 0 and lock to 0.
  - Otherwise, with enable=1, lockTmr increments, saturating at LOCK_LEN.
  - lock<=1 when lockTmr reaches LOCK_LEN; lock stays high until the next pulse, kExp change or reset.
  - enable=0 holds lockTmr.
- Reset mid-operation: all state clears immediately, including any carry/borrow pulse in progress (it is truncated).

Decomposition:
- Shared package dpll_pkg:
  - CNT_W, KEXP_OFS, LOCK_W, LOCK_LEN defaults.
  - Helper function for the terminal value from an exponent.
- One sub-module is natural: mod_k_counter, instantiated twice (up and down). It has:
  - ports clk, reset, inc, clr, kc, wrap (registered pulse), cnt;
  - parameter CNT_W.
- The lock timer and kExp change detection stay in the top level.

Test Plan:
- Wrap up: kExp=0, enable=1, dnUp=0 for 20 cycles -> carry pulses after edges 8 and 16 only, each 1 cycle wide; upCnt=4 at end; dnCnt=0; borrow never high.
- Wrap down: kExp=1, dnUp=1 for 16 enabled edges -> borrow pulses once after edge 16; dnCnt=0 afterwards; upCnt unchanged.
- Mixed/enable:
  - Alternate dnUp 0/1 for 14 edges with K=8 -> upCnt=7, dnCnt=7, no pulses.
  - Then deassert enable for 5 cycles -> counters hold.
  - Next dnUp=0 enabled edge -> carry.
- kExp change: mid-count (upCnt=5), change kExp 0->2 -> next cycle upCnt=0, lock=0, no pulse; subsequent carry only after 32 dnUp=0 edges.
- Lock (LOCK_LEN=2000): enabled pulse-free operation -> lock asserts after exactly 2000 enabled cycles without carry/borrow. A subsequent carry -> lock=0 in the same cycle carry asserts.
- Async reset: assert reset mid-count, between clock edges -> all outputs 0 immediately. Release -> counting restarts from 0 with the first carry after K edges.
